// File: rtl/uart_pkg.sv
// Shared definitions for the UART IO-port blocks: port addresses, status
// bit positions and the receiver state encoding.
package uart_pkg;

  // IO port map (transmitter on 8/10, receiver on 9/11)
  localparam logic [7:0] UART_TX_DATA = 8'd8;
  localparam logic [7:0] UART_RX_DATA = 8'd9;
  localparam logic [7:0] UART_TX_STAT = 8'd10;
  localparam logic [7:0] UART_RX_STAT = 8'd11;

  // Bit positions inside the receive status byte
  localparam int RX_READY   = 0;
  localparam int RX_OVERRUN = 1;
  localparam int RX_FERR    = 2;
  localparam int RX_BUSY    = 3;

  // Receiver frame states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: input synchroniser, frame FSM and shift register.
// Emits a one-clock data_out_valid pulse per completed frame; ferr_pulse
// accompanies it when the stop bit was sampled low.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int BIT_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       ferr_pulse,
  output logic       busy_rx
);

  localparam int DIV_W = $clog2(BIT_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(BIT_DIV);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic            sync_reg;
  logic            rx_s;
  rx_state_t       state_reg, state_next;
  logic [DIV_W-1:0] div_reg, div_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic            valid_reg, valid_next;
  logic            ferr_reg, ferr_next;
  logic            expire;

  // A loaded divider value N expires exactly N clocks after loading.
  assign expire = (div_reg <= DIV_ONE);

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      sync_reg <= rx_pin;
      rx_s     <= sync_reg;
    end
  end

  // Frame state, divider, bit index, shift register and output pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      div_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      div_reg   <= div_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Next-state logic: sample each bit at its centre, LSB first.
  always_comb begin
    state_next = state_reg;
    div_next   = div_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          div_next   = DIV_HALF;
          state_next = START;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            div_next   = DIV_FULL;
            idx_next   = 3'd0;
            state_next = DATA;
          end else begin
            // Line went back high before mid-start: treat as noise.
            state_next = IDLE;
          end
        end else begin
          div_next = div_reg - DIV_ONE;
        end
      end
      DATA: begin
        if (expire) begin
          shift_next = {rx_s, shift_reg[7:1]};
          div_next   = DIV_FULL;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          div_next = div_reg - DIV_ONE;
        end
      end
      STOP: begin
        if (expire) begin
          valid_next = 1'b1;
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            // Low stop bit: flag it and wait out a break so it yields one byte.
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          div_next = div_reg - DIV_ONE;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign data_out       = shift_reg;
  assign data_out_valid = valid_reg;
  assign ferr_pulse     = ferr_reg;
  assign busy_rx        = (state_reg != IDLE);

endmodule

// File: rtl/uart_rx_io.sv
// UART receiver with Z80-style IO ports: data at 9, status at 11.
// Both ports are read-to-clear; clearing happens when the read decode
// falls so the value on the bus stays stable for the whole access.
module uart_rx_io
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD       = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Address,
  inout  wire  [7:0] Data,
  input  logic       IORQ,
  input  logic       RD,
  input  logic       WR,
  input  logic       uart_rx,
  output logic       uart_rx_int
);

  localparam int BIT_DIV = CLOCK_FREQ / BAUD;

  logic [7:0] core_data;
  logic       core_valid;
  logic       core_ferr;
  logic       busy;

  logic       data_rd;
  logic       stat_rd;
  logic       data_rd_reg;
  logic       stat_rd_reg;
  logic       data_end;
  logic       stat_end;

  logic [7:0] rx_data_reg;
  logic       rx_ready_reg;
  logic       overrun_reg;
  logic       ferr_reg;

  logic [7:0] status;
  logic [7:0] bus_val;
  logic       drive_en;

  uart_rx_core #(
    .BIT_DIV(BIT_DIV)
  ) u_core (
    .clk           (clk),
    .rst           (reset),
    .rx_pin        (uart_rx),
    .data_out      (core_data),
    .data_out_valid(core_valid),
    .ferr_pulse    (core_ferr),
    .busy_rx       (busy)
  );

  assign data_rd  = (Address == UART_RX_DATA) && IORQ && RD && !WR;
  assign stat_rd  = (Address == UART_RX_STAT) && IORQ && RD && !WR;
  assign data_end = data_rd_reg && !data_rd;
  assign stat_end = stat_rd_reg && !stat_rd;

  // Remember last cycle's decodes to detect the end of each access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_rd_reg <= 1'b0;
      stat_rd_reg <= 1'b0;
    end else begin
      data_rd_reg <= data_rd;
      stat_rd_reg <= stat_rd;
    end
  end

  // Holding register and flags; later assignments give set priority over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data_reg  <= 8'h00;
      rx_ready_reg <= 1'b0;
      overrun_reg  <= 1'b0;
      ferr_reg     <= 1'b0;
    end else begin
      if (stat_end) begin
        overrun_reg <= 1'b0;
        ferr_reg    <= 1'b0;
      end
      if (core_valid) begin
        // A byte being read out right now frees the slot for the new one.
        if (!rx_ready_reg || data_end) begin
          rx_data_reg  <= core_data;
          rx_ready_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
        if (core_ferr) begin
          ferr_reg <= 1'b1;
        end
      end else if (data_end) begin
        rx_ready_reg <= 1'b0;
      end
    end
  end

  // Status byte assembled from the flag registers and the core's busy.
  always_comb begin
    status             = 8'h00;
    status[RX_READY]   = rx_ready_reg;
    status[RX_OVERRUN] = overrun_reg;
    status[RX_FERR]    = ferr_reg;
    status[RX_BUSY]    = busy;
  end

  assign drive_en    = data_rd || stat_rd;
  assign bus_val     = data_rd ? rx_data_reg : status;
  assign Data        = drive_en ? bus_val : 8'hzz;
  assign uart_rx_int = rx_ready_reg;

endmodule

// File: doc/uart_rx_io.md
Name: uart_rx_io

Overview:
- RS232 (UART) receiver block with its Z80-style IO-port interface; the receive-side companion of the UART transmitter on IO ports 8/10.
- Deserialises 8N1 frames from the `uart_rx` pin into a one-byte holding register.
- Exposes two read ports: received data at IO address 9, receive status at IO address 11. Both are read-to-clear.
- Positive-logic bus signalling, matching the transmitter port.

Parameters:
- CLOCK_FREQ, 50000000, clk frequency in Hz.
- BAUD, 115200, serial bit rate.
- BIT_DIV, CLOCK_FREQ/BAUD (truncated), clocks per bit; local, not overridable.

Ports:
- clk  input  1  system clock; all state on posedge.
- reset  input  1  asynchronous, active-high reset.
- Address  input  8  IO address.
- Data  inout  8  IO data bus; driven only during a decoded read, otherwise 8'hZZ.
- IORQ  input  1  IO request, active high.
- RD  input  1  read strobe, active high.
- WR  input  1  write strobe, active high.
- uart_rx  input  1  serial input; idle high.
- uart_rx_int  output  1  equals rx_ready; intended for interrupt/poll use.

Behaviour:
- **Input synchroniser.** uart_rx passes through a 2-flop synchroniser (rx_s); both flops reset to 1.
- **Reset state.** FSM = IDLE. Bit counter and divider = 0. rx_data = 8'h00. rx_ready, overrun and ferr = 0. uart_rx_int = 0. Data = Z.
- **IDLE.** When rx_s == 0, load divider with BIT_DIV/2 and go to START.
- **START.** When the divider expires, sample rx_s:
  - 0 -> load BIT_DIV, bit index 0, go to DATA.
  - 1 -> false start; return to IDLE with no flags changed.
- **DATA.** Every BIT_DIV clocks, sample rx_s into the shift register, LSB first. After bit 7, load BIT_DIV and go to STOP.
- **STOP.** When the divider expires, sample rx_s and complete the byte:
  - stop bit 1 -> go to IDLE.
  - stop bit 0 -> set ferr and go to WAIT_HIGH.
  - In both cases the byte is delivered to the holding register.
- **WAIT_HIGH.** Stay until rx_s == 1, then go to IDLE. A held break yields exactly one byte.
- **Delivery latency.** rx_data and rx_ready update on the clock after the stop-bit sample.
- **Read decodes.**
  - data_rd = Address==9 && IORQ && RD && !WR.
  - stat_rd = Address==11 && IORQ && RD && !WR.
- **Bus drive.**
  - During data_rd: Data = rx_data.
  - During stat_rd: Data = {4'b0, busy, ferr, overrun, rx_ready}, where busy = (FSM != IDLE).
  - Otherwise Data = Z.
- **Read-to-clear.** Clearing happens on the clock where the decode falls (end of access), so the value read is stable for the whole access.
  - End of data_rd clears rx_ready.
  - End of stat_rd clears overrun and ferr.
- **Byte completion while rx_ready == 1 and no data_rd ending that clock:** the new byte is discarded, rx_data is unchanged and overrun is set. This includes completion during an active data_rd.
- **Simultaneous completion and end of data_rd:** the new byte is loaded, rx_ready stays 1, overrun is not set.
- **Simultaneous ferr set and end of stat_rd:** set wins.
- **Writes.** Writes to addresses 9/11 have no effect.
- **Mid-operation reset.** Reset asserted mid-frame returns everything to reset values immediately. The partial frame is lost. The next full frame is received normally.

Decomposition:
- Package uart_pkg holds:
  - IO address constants UART_TX_DATA=8, UART_RX_DATA=9, UART_TX_STAT=10, UART_RX_STAT=11.
  - Status bit indices RX_READY=0, RX_OVERRUN=1, RX_FERR=2, RX_BUSY=3.
  - rx FSM enum {IDLE, START, DATA, STOP, WAIT_HIGH}.
- Sub-module uart_rx_core, the counterpart of uart_core:
  - Contains the synchroniser, FSM and shift register.
  - Outputs data_out[7:0], data_out_valid (1-clk pulse), ferr_pulse and busy_rx.
- uart_rx_io keeps the holding register, flags, decode and tri-state bus.

Test Plan (CLOCK_FREQ=1600000, BAUD=100000 -> BIT_DIV=16):
- Frame 0x41 with valid stop -> rx_ready=1 one clock after stop sample. Status read gives 0x01, data read gives 0x41, next status read gives 0x00, uart_rx_int=0.
- 4-clock low glitch on uart_rx while idle -> busy seen briefly, returns to IDLE, no byte, status 0x00.
- Frames 0x55 then 0xAA with no read between -> status 0x03, data 0x55. Following status read gives 0x00 (overrun cleared).
- Line held low for 12 bit times -> one byte 0x00, status 0x05 (ferr+ready), no second byte until line high. A subsequent frame 0x33 is received correctly.
- Reset pulsed mid-DATA of a frame -> all flags 0, Data=Z. Next frame 0x7E is received as 0x7E.
- Check Data stays Z in each case:
  - reads at address 8 or 10;
  - IORQ=0;
  - writes to address 9.
- Second byte completing on exactly the clock data_rd ends -> new byte held, rx_ready=1, overrun=0.
